stopwatch_ctrl: RTL and testbench

Start/stop/clear stopwatch that sits directly downstream of the tick counter and consumes its one-cycle `tic` pulse. Accumulates tics into an NDIG-digit BCD count under a three-state control FSM driven by two debounced buttons. Also drives the upstream counter's enable so the tick source runs only while timing. Output digits feed the seven-segment display path.

---
 rtl/stopwatch_pkg.sv | 9 +
 rtl/bcd_digit.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 83 ++++++++
 tb/tb_stopwatch_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   localparam int unsigned DIG_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch count; carry ripples to the next digit.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [DIG_W-1:0] digit,
   output logic             carry
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digit <= '0;
      end else if (clr) begin
         digit <= '0;
      end else if (inc) begin
         digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
      end
   end

   assign carry = inc & (digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch: button edge detect, control FSM, sticky overflow
// and an NDIG-digit BCD carry chain.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned NDIG = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tic,
   input  logic                  btn_ss,
   input  logic                  btn_clr,
   output logic                  tick_en,
   output logic [DIG_W*NDIG-1:0] digits,
   output logic                  running,
   output logic                  overflow
);

   state_t            state;
   logic              ss_q, clr_q;
   logic              ss_press, clr_press;
   logic [NDIG-1:0]   inc;
   logic [NDIG-1:0]   carry;

   assign ss_press  = btn_ss & ~ss_q;
   assign clr_press = btn_clr & ~clr_q;

   // Clear beats everything; a stop press still counts its coincident tic.
   assign inc[0] = (state == RUN) & tic & ~clr_press;

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      bcd_digit u_dig (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr_press),
         .inc   (inc[i]),
         .digit (digits[i*DIG_W +: DIG_W]),
         .carry (carry[i])
      );
      if (i > 0) begin : g_chain
         assign inc[i] = carry[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ss_q     <= 1'b0;
         clr_q    <= 1'b0;
         running  <= 1'b0;
         tick_en  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         ss_q  <= btn_ss;
         clr_q <= btn_clr;
         if (clr_press) begin
            state    <= IDLE;
            running  <= 1'b0;
            tick_en  <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (carry[NDIG-1]) begin
               overflow <= 1'b1;
            end
            if (ss_press) begin
               case (state)
                  RUN: begin
                     state   <= PAUSE;
                     running <= 1'b0;
                     tick_en <= 1'b0;
                  end
                  default: begin
                     state   <= RUN;
                     running <= 1'b1;
                     tick_en <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus hand-written corner sequences.
module tb_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tic, btn_ss, btn_clr;
   logic        tick_en, running, overflow;
   logic [15:0] digits;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ss;
      logic        clr;
      logic        tic;
      logic [15:0] d;
      logic        r;
      logic        o;
   } vec_t;

   vec_t tbl[$];

   stopwatch_ctrl #(.NDIG(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .tic      (tic),
      .btn_ss   (btn_ss),
      .btn_clr  (btn_clr),
      .tick_en  (tick_en),
      .digits   (digits),
      .running  (running),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      int          v;
      r = '0;
      v = n;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] d, input logic r,
                            input logic o);
      check({name, ".digits"}, digits, d);
      check({name, ".running"}, 16'(running), 16'(r));
      check({name, ".tick_en"}, 16'(tick_en), 16'(r));
      check({name, ".overflow"}, 16'(overflow), 16'(o));
   endtask

   task automatic step(input logic ss, input logic clr, input logic t);
      btn_ss  = ss;
      btn_clr = clr;
      tic     = t;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic ss, input logic clr, input logic t, input logic [15:0] d,
                      input logic r, input logic o);
      vec_t v;
      v.ss = ss; v.clr = clr; v.tic = t; v.d = d; v.r = r; v.o = o;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b0; tic = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Start, 12 tics, run on to 99, pause through 5 tics, resume, one tic.
      add(1, 0, 0, 16'h0000, 1, 0);
      for (int i = 1; i <= 99; i++) add(0, 0, 1, to_bcd(i), 1, 0);
      add(1, 0, 0, 16'h0099, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 1, 16'h0099, 0, 0);
      add(1, 0, 0, 16'h0099, 1, 0);
      add(0, 0, 1, 16'h0100, 1, 0);

      foreach (tbl[k]) begin
         step(tbl[k].ss, tbl[k].clr, tbl[k].tic);
         if (k == 12 || k >= 99) check_all($sformatf("vec%0d", k), tbl[k].d, tbl[k].r, tbl[k].o);
         else check($sformatf("vec%0d.digits", k), digits, tbl[k].d);
      end

      // clr + ss + tic together in RUN at 42.
      step(0, 1, 0);
      check_all("clr_run", 16'h0000, 0, 0);
      step(1, 0, 0);
      repeat (42) step(0, 0, 1);
      check_all("at42", 16'h0042, 1, 0);
      step(1, 1, 1);
      check_all("clr_ss_tic", 16'h0000, 0, 0);
      step(0, 0, 1);
      check_all("idle_tic", 16'h0000, 0, 0);

      // Held start button gives one press only.
      for (int i = 0; i < 50; i++) begin
         step(1, 0, 0);
         check($sformatf("held_ss%0d", i), 16'(running), 16'h1);
      end
      repeat (7) step(1, 0, 1);
      check_all("held_tics", 16'h0007, 1, 0);
      step(0, 0, 0);
      step(1, 0, 1);
      check_all("stop_tic", 16'h0008, 0, 0);
      step(0, 0, 1);
      check_all("paused_tic", 16'h0008, 0, 0);

      // Wrap from 9999.
      step(0, 1, 0);
      step(1, 0, 0);
      repeat (9999) step(0, 0, 1);
      check_all("at9999", 16'h9999, 1, 0);
      step(0, 0, 1);
      check_all("wrap", 16'h0000, 1, 1);
      repeat (345) step(0, 0, 1);
      check_all("at345_ovf", 16'h0345, 1, 1);

      // Asynchronous reset between edges, then button held through release.
      tic = 1'b0;
      rst = 1'b0;
      #1;
      check_all("async_rst", 16'h0000, 0, 0);
      btn_ss = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all("held_thru_rst", 16'h0000, 1, 0);
      step(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
